// File: rtl/mema_feed_if.sv
// mema_feed_if: handshake/control bundle between mema_feed_ctrl (master) and its requester/memory side (slave)
// Signals: start, row_valid, row_ready, mem_wren, mem_arow, mem_en, feed_idx, busy, done
// Optional: feed_stall exists only when MEMA_FEED_STALL_EN is defined
interface mema_feed_if #(
    parameter int DIM         = 8,
    parameter int FEED_CYCLES = 3*DIM-2,
    parameter int CNT_W       = $clog2(FEED_CYCLES+1)
);
    logic             start;
    logic             row_valid;
    logic             row_ready;
    logic             mem_wren;
    logic [$clog2(DIM)-1:0] mem_arow;
    logic             mem_en;
    logic [CNT_W-1:0] feed_idx;
    logic             busy;
    logic             done;
`ifdef MEMA_FEED_STALL_EN
    logic             feed_stall;
    modport master (input start, row_valid, feed_stall,
                    output row_ready, mem_wren, mem_arow, mem_en, feed_idx, busy, done);
    modport slave  (output start, row_valid, feed_stall,
                    input row_ready, mem_wren, mem_arow, mem_en, feed_idx, busy, done);
`else
    modport master (input start, row_valid,
                    output row_ready, mem_wren, mem_arow, mem_en, feed_idx, busy, done);
    modport slave  (output start, row_valid,
                    input row_ready, mem_wren, mem_arow, mem_en, feed_idx, busy, done);
`endif
endinterface

// File: rtl/mema_feed_ctrl.sv
// mema_feed_ctrl: LOAD/FEED sequencer for the A-operand skew memory of the systolic array
// Ports: clk, rst (sync, active-high); bus (mema_feed_if.master):
//   start/row_valid in; row_ready, mem_wren (combinational); mem_arow, mem_en, feed_idx, busy, done (registered)
// Optional: define MEMA_FEED_STALL_EN to add feed_stall, which pauses FEED without losing mem_en cycles
module mema_feed_ctrl #(
    parameter int DIM         = 8,
    parameter int FEED_CYCLES = 3*DIM-2,
    parameter int CNT_W       = $clog2(FEED_CYCLES+1)
) (
    input logic        clk,
    input logic        rst,
    mema_feed_if.master bus
);
    localparam int AW = $clog2(DIM);
    localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, FEED = 2'd2, DONE = 2'd3;
    logic [1:0]       state, state_n;
    logic [AW-1:0]    row, row_n;
    logic [CNT_W-1:0] feed, feed_n;
    logic             en_q, stall;
`ifdef MEMA_FEED_STALL_EN
    assign stall = bus.feed_stall & (state == FEED);
`else
    assign stall = 1'b0;
`endif
    assign bus.row_ready = state == LOAD;
    assign bus.mem_wren  = bus.row_valid & bus.row_ready;
    assign bus.mem_en    = en_q & ~stall;
    // Both counters are cleared on leaving their phase, so they read 0 elsewhere
    assign bus.mem_arow  = row;
    assign bus.feed_idx  = feed;
    always_comb begin
        state_n = state;
        row_n   = row;
        feed_n  = feed;
        case (state)
            IDLE: if (bus.start) begin
                state_n = LOAD;
                row_n   = '0;
            end
            LOAD: if (bus.mem_wren) begin
                state_n = row == AW'(DIM-1) ? FEED : LOAD;
                row_n   = row == AW'(DIM-1) ? '0 : row + 1'b1;
            end
            FEED: if (!stall) begin
                state_n = feed == CNT_W'(FEED_CYCLES-1) ? DONE : FEED;
                feed_n  = feed == CNT_W'(FEED_CYCLES-1) ? '0 : feed + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            row      <= '0;
            feed     <= '0;
            en_q     <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            state    <= state_n;
            row      <= row_n;
            feed     <= feed_n;
            en_q     <= state_n == FEED;
            bus.busy <= state_n == LOAD || state_n == FEED;
            bus.done <= state_n == DONE;
        end
    end
endmodule

// File: tb/tb_mema_feed_ctrl.sv
// tb_mema_feed_ctrl: randomized self-checking bench for mema_feed_ctrl against a row/feed count model
module tb_mema_feed_ctrl;
    localparam int DIM   = 8;
    localparam int FC    = 3*DIM-2;
    localparam int CNT_W = $clog2(FC+1);
    localparam int AW    = $clog2(DIM);
    localparam int OW    = 5 + AW + CNT_W;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int vectors = 0;
    int miscompares = 0;
    mema_feed_if #(.DIM(DIM), .FEED_CYCLES(FC)) bus();
    mema_feed_ctrl #(.DIM(DIM), .FEED_CYCLES(FC)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic st, input logic v, input logic s);
        bus.start = st;
        bus.row_valid = v;
`ifdef MEMA_FEED_STALL_EN
        bus.feed_stall = s;
`else
        if (s) bus.start = st;
`endif
    endtask
    task automatic test_reset;
        int dones, ens;
        rst = 1'b1;
        drive(0, 1, 0);
        repeat (2) next_cycle;
        @(negedge clk);
        vectors++;
        if ({bus.busy, bus.mem_en, bus.done, bus.row_ready, bus.mem_wren} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags got %b exp 00000", {bus.busy, bus.mem_en, bus.done, bus.row_ready, bus.mem_wren});
        end
        vectors++;
        if (bus.mem_arow !== '0 || bus.feed_idx !== '0) begin
            miscompares++;
            $display("FAIL reset_counts arow %0d idx %0d exp 0 0", bus.mem_arow, bus.feed_idx);
        end
        next_cycle;
        rst = 1'b0;
        drive(1, 1, 0);
        next_cycle;
        drive(0, 1, 0);
        repeat (DIM + 10) next_cycle;
        @(negedge clk);
        vectors++;
        if (bus.mem_en !== 1'b1 || bus.feed_idx !== CNT_W'(10)) begin
            miscompares++;
            $display("FAIL reset_prefeed en %b idx %0d exp 1 10", bus.mem_en, bus.feed_idx);
        end
        rst = 1'b1;
        repeat (2) next_cycle;
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bus.busy, bus.mem_en, bus.row_ready} !== 3'b0 || bus.feed_idx !== '0) begin
            miscompares++;
            $display("FAIL reset_midfeed busy/en/ready %b idx %0d exp 000 0", {bus.busy, bus.mem_en, bus.row_ready}, bus.feed_idx);
        end
        dones = 0;
        ens = 0;
        repeat (40) begin
            @(negedge clk);
            dones += int'(bus.done);
            ens += int'(bus.mem_en);
        end
        vectors++;
        if (dones !== 0 || ens !== 0) begin
            miscompares++;
            $display("FAIL reset_nodone dones %0d ens %0d exp 0 0", dones, ens);
        end
        drive(0, 0, 0);
        next_cycle;
    endtask
    task automatic test_simul_reset;
        int ens, busys;
        drive(1, 0, 0);
        next_cycle;
        drive(0, 1, 0);
        repeat (DIM - 1) next_cycle;
        @(negedge clk);
        vectors++;
        if (bus.mem_wren !== 1'b1 || bus.mem_arow !== AW'(DIM-1)) begin
            miscompares++;
            $display("FAIL simul_lastrow wren %b arow %0d exp 1 %0d", bus.mem_wren, bus.mem_arow, DIM-1);
        end
        rst = 1'b1;
        next_cycle;
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bus.busy, bus.row_ready, bus.mem_wren, bus.mem_en} !== 4'b0) begin
            miscompares++;
            $display("FAIL simul_idle busy/ready/wren/en %b exp 0000", {bus.busy, bus.row_ready, bus.mem_wren, bus.mem_en});
        end
        ens = 0;
        busys = 0;
        repeat (30) begin
            @(negedge clk);
            ens += int'(bus.mem_en) + int'(bus.done);
            busys += int'(bus.busy);
        end
        vectors++;
        if (ens !== 0 || busys !== 0) begin
            miscompares++;
            $display("FAIL simul_nofeed en+done %0d busy %0d exp 0 0", ens, busys);
        end
        drive(0, 0, 0);
        next_cycle;
    endtask
    // mode: 0 back-to-back, 1 gapped 1/0, 2 random valid/start/stall, 3 stall 3 cycles at feed_idx 5
    task automatic test_tile(input int mode);
        int acc, fed, cyc, writes, ens, done_cyc, sc, exp_done;
        bit v, s, fin, in_load, in_feed, in_done;
        logic [OW-1:0] got, exp;
        acc = 0; fed = 0; cyc = 1; writes = 0; ens = 0; done_cyc = -1; sc = 0; fin = 0;
        drive(1, 0, 0);
        @(negedge clk);
        vectors++;
        if ({bus.busy, bus.done, bus.mem_en, bus.row_ready} !== 4'b0) begin
            miscompares++;
            $display("FAIL tile%0d idle_at_start got %b exp 0000", mode, {bus.busy, bus.done, bus.mem_en, bus.row_ready});
        end
        next_cycle;
        while (!fin && cyc < 400) begin
            in_load = acc < DIM;
            in_feed = !in_load && fed < FC;
            in_done = !in_load && !in_feed;
            v = mode == 0 ? 1'b1 : mode == 1 ? cyc[0] : mode == 2 ? 1'($urandom_range(1)) : 1'b1;
            s = 1'b0;
`ifdef MEMA_FEED_STALL_EN
            if (mode == 2) s = $urandom_range(3) == 0;
            if (mode == 3 && in_feed && fed == 5 && sc < 3) begin
                s = 1'b1;
                sc++;
            end
`endif
            drive((mode == 2 && $urandom_range(4) == 0) || in_done, v, s);
            @(negedge clk);
            got = {bus.row_ready, bus.mem_wren, bus.mem_en, bus.busy, bus.done, bus.mem_arow, bus.feed_idx};
            exp = {in_load, in_load && v, in_feed && !s, in_load || in_feed, in_done,
                   AW'(in_load ? acc : 0), CNT_W'(in_feed ? fed : 0)};
            vectors++;
            if (got !== exp) begin
                miscompares++;
                $display("FAIL tile%0d cyc%0d {ready,wren,en,busy,done,arow,idx} got %h exp %h", mode, cyc, got, exp);
            end
            writes += int'(bus.mem_wren);
            ens += int'(bus.mem_en);
            if (in_load && v) acc++;
            else if (in_feed && !s) fed++;
            else if (in_done) begin
                fin = 1;
                done_cyc = cyc;
            end
            next_cycle;
            cyc++;
        end
        vectors++;
        if (!fin) begin
            miscompares++;
            $display("FAIL tile%0d timeout no done after %0d cycles exp done", mode, cyc);
        end
        drive(0, 0, 0);
        repeat (4) begin
            @(negedge clk);
            vectors++;
            if ({bus.busy, bus.done, bus.mem_en, bus.row_ready} !== 4'b0) begin
                miscompares++;
                $display("FAIL tile%0d idle_after got %b exp 0000", mode, {bus.busy, bus.done, bus.mem_en, bus.row_ready});
            end
            next_cycle;
        end
        vectors++;
        if (writes !== DIM || ens !== FC) begin
            miscompares++;
            $display("FAIL tile%0d totals writes %0d ens %0d exp %0d %0d", mode, writes, ens, DIM, FC);
        end
        exp_done = mode == 0 ? DIM + FC + 1 : mode == 1 ? 2*DIM - 1 + FC + 1 : mode == 3 ? DIM + FC + 4 : done_cyc;
        if (mode != 2) begin
            vectors++;
            if (done_cyc !== exp_done) begin
                miscompares++;
                $display("FAIL tile%0d latency done_cyc %0d exp %0d", mode, done_cyc, exp_done);
            end
        end
    endtask
    initial begin
        drive(0, 0, 0);
        test_reset;
        test_tile(0);
        test_tile(1);
        repeat (3) test_tile(2);
`ifdef MEMA_FEED_STALL_EN
        test_tile(3);
`endif
        test_simul_reset;
        test_tile(0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end
endmodule
